// File: rtl/ranperm_seq_ctrl.sv
// rtl/ranperm_seq_ctrl.sv - Fisher-Yates permutation sequencer with LFSR and streaming output
//
// Builds a random permutation of 0..N-1 in an internal index array, one swap per
// cycle, then streams the entries out over a valid/ready port.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a new run (honoured in IDLE only)
//   seed_valid in   load seed into the LFSR (honoured in IDLE only)
//   seed       in   32-bit seed; zero is replaced by LFSR_SEED
//   out_ready  in   consumer accepts the current entry
//   abort      in   (RANPERM_ABORT_EN only) drop the current run, back to IDLE
//   busy       out  run in progress (INIT, SHUFFLE, STREAM)
//   done       out  one-cycle pulse after the last accepted entry
//   out_valid  out  entry available
//   out_index  out  current permutation entry
//   out_last   out  entry N-1 is being presented
//
// Build option: define RANPERM_ABORT_EN to add the abort input.

module ranperm_seq_ctrl #(
    parameter int          N         = 16,
    // Derived from N; not meant to be overridden.
    parameter int          W         = $clog2(N),
    parameter logic [31:0] LFSR_SEED = 32'h0000ABCD
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         seed_valid,
    input  logic [31:0]  seed,
    input  logic         out_ready,
`ifdef RANPERM_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    output logic [W-1:0] out_index,
    output logic         out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_STREAM
    } state_t;

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    state_t         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [W-1:0]   k_q, k_d;
    logic [W-1:0]   i_q, i_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_index_q, out_index_d;
    logic           out_last_q, out_last_d;
    logic           done_q, done_d;

    logic [W-1:0]   mem_q [N];

    logic [31:0]    lfsr_next;
    logic [W:0]     i_plus1;
    logic [W-1:0]   j_idx;

    assign lfsr_next = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    // Scale the LFSR onto 0..i by taking the top bits of lfsr*(i+1); the
    // product never reaches (i+1)<<32, so j <= i without a divider.
    assign i_plus1 = {1'b0, i_q} + (W + 1)'(1);
    assign j_idx   = W'((64'(lfsr_q) * 64'(i_plus1)) >> 32);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        k_d         = k_q;
        i_d         = i_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (seed_valid) begin
                    lfsr_d = (seed == 32'd0) ? LFSR_SEED : seed;
                end
                if (start) begin
                    state_d = S_INIT;
                    k_d     = '0;
                end
            end
            S_INIT: begin
                k_d = k_q + W'(1);
                if (k_q == LAST_IDX) begin
                    state_d = S_SHUFFLE;
                    i_d     = LAST_IDX;
                end
            end
            S_SHUFFLE: begin
                lfsr_d = lfsr_next;
                i_d    = i_q - W'(1);
                if (i_q == W'(1)) begin
                    state_d = S_STREAM;
                    k_d     = '0;
                end
            end
            S_STREAM: begin
                if (!out_valid_q) begin
                    // Setup cycle: present entry 0.
                    out_valid_d = 1'b1;
                    out_index_d = mem_q[k_q];
                    out_last_d  = (k_q == LAST_IDX);
                    k_d         = k_q + W'(1);
                end else if (out_ready) begin
                    if (out_last_q) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_index_d = '0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_index_d = mem_q[k_q];
                        out_last_d  = (k_q == LAST_IDX);
                        k_d         = k_q + W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef RANPERM_ABORT_EN
        // Abort overrides everything above; the LFSR keeps the value it had.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            lfsr_d      = lfsr_q;
            out_valid_d = 1'b0;
            out_index_d = '0;
            out_last_d  = 1'b0;
            done_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            k_q         <= '0;
            i_q         <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            k_q         <= k_d;
            i_q         <= i_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Index array has no reset; INIT rewrites every entry before it is read.
    // When i == j both writes carry the same value, so the swap is a no-op.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[k_q] <= k_q;
        end else if (state_q == S_SHUFFLE) begin
            mem_q[i_q]   <= mem_q[j_idx];
            mem_q[j_idx] <= mem_q[i_q];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ranperm_seq_ctrl.sv
// tb/tb_ranperm_seq_ctrl.sv - self-checking bench for ranperm_seq_ctrl

module tb_ranperm_seq_ctrl;

    localparam int          N    = 8;
    localparam int          W    = $clog2(N);
    localparam logic [31:0] SEED = 32'h0000ABCD;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         seed_valid;
    logic [31:0]  seed;
    logic         out_ready;
`ifdef RANPERM_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         done;
    logic         out_valid;
    logic [W-1:0] out_index;
    logic         out_last;

    ranperm_seq_ctrl #(.N(N), .LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .seed_valid (seed_valid),
        .seed       (seed),
        .out_ready  (out_ready),
`ifdef RANPERM_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        logic [31:0] sd;
        int          stall_beat;
        int          stall_len;
        bit          rnd_ready;
        bit          poke_start;
        int          abort_beat;
        int          exp_first;
        int          exp_beats;
    } vec_t;

    vec_t        tbl[$];
    int          n_checks;
    int          n_err;
    logic [31:0] model_lfsr;
    int          exp_perm[N];
    int          first_perm[N];
    int          got_perm[N];
    int          seen[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Textbook Fisher-Yates from the top index down, consuming one LFSR value per step.
    task automatic model_perm();
        longint unsigned prod;
        int j, t;
        for (int k = 0; k < N; k++) exp_perm[k] = k;
        for (int i = N - 1; i >= 1; i--) begin
            prod = 64'(model_lfsr) * 64'(i + 1);
            j = int'(prod >> 32);
            t = exp_perm[i];
            exp_perm[i] = exp_perm[j];
            exp_perm[j] = t;
            model_lfsr = lstep(model_lfsr);
        end
    endtask

    function automatic vec_t mk(bit ld, logic [31:0] sd, int sb, int sl, bit rr, bit ps, int ab, int eb);
        vec_t v;
        v.ld = ld; v.sd = sd; v.stall_beat = sb; v.stall_len = sl;
        v.rnd_ready = rr; v.poke_start = ps; v.abort_beat = ab;
        v.exp_first = 2 * N; v.exp_beats = eb;
        return v;
    endfunction

    task automatic do_run(input vec_t v);
        int cyc, beats, first_v, stalls, stall_cnt, bad;
        bit fin, held, rdy, aborting;
        logic [W-1:0] h_idx;
        logic h_last;
        @(negedge clk);
        start = 1'b1; seed_valid = v.ld; seed = v.sd; out_ready = 1'b0;
        if (v.ld) model_lfsr = (v.sd == 32'd0) ? SEED : v.sd;
        model_perm();
        foreach (seen[k]) begin seen[k] = 0; got_perm[k] = -1; end
        @(negedge clk);
        start = 1'b0; seed_valid = 1'b0;
        chk("busy_on_start", 32'(busy), 32'd1);
        cyc = 0; beats = 0; first_v = -1; stalls = 0; stall_cnt = 0;
        fin = 0; held = 0; aborting = 0; h_idx = '0; h_last = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = v.poke_start && (cyc == 5 || cyc == 2 * N + 2);
            if (cyc > 400) begin
                n_checks++; n_err++;
                $display("FAIL run_timeout: no done after %0d cycles", cyc);
                fin = 1;
            end else if (aborting) begin
`ifdef RANPERM_ABORT_EN
                abort = 1'b0;
`endif
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_last", 32'(out_last), 32'd0);
                fin = 1;
            end else if (done) begin
                chk("done_cycle", 32'(cyc), 32'(3 * N + stalls));
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_valid", 32'(out_valid), 32'd0);
                bad = 0;
                foreach (seen[k]) if (seen[k] != 1) bad++;
                chk("coverage", 32'(bad), 32'd0);
                fin = 1;
            end else begin
                if (held) begin
                    chk("hold_index", 32'(out_index), 32'(h_idx));
                    chk("hold_last", 32'(out_last), 32'(h_last));
                end
                held = 0;
                rdy = 1'b1;
                if (out_valid) begin
                    if (first_v < 0) first_v = cyc;
                    if (v.rnd_ready) rdy = ($urandom_range(0, 3) != 0);
                    else if (beats == v.stall_beat && stall_cnt < v.stall_len) begin
                        rdy = 1'b0; stall_cnt++;
                    end
`ifdef RANPERM_ABORT_EN
                    if (v.abort_beat >= 0 && beats == v.abort_beat) begin
                        abort = 1'b1; rdy = 1'b0; aborting = 1;
                    end
`endif
                    if (rdy) begin
                        if (beats < N) begin
                            chk("beat_index", 32'(out_index), 32'(exp_perm[beats]));
                            chk("beat_last", 32'(out_last), 32'(beats == N - 1));
                            got_perm[beats] = int'(out_index);
                            if (int'(out_index) < N) seen[out_index]++;
                        end else begin
                            n_checks++; n_err++;
                            $display("FAIL extra_beat: beat %0d beyond %0d", beats, N);
                        end
                        beats++;
                    end else if (!aborting) begin
                        held = 1; h_idx = out_index; h_last = out_last; stalls++;
                    end
                end
                out_ready = rdy;
            end
        end
        out_ready = 1'b0;
        start = 1'b0;
        chk("first_valid", 32'(first_v), 32'(v.exp_first));
        chk("beat_count", 32'(beats), 32'(v.exp_beats));
        if (!aborting) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        reset_n = 1'b0; start = 1'b0; seed_valid = 1'b0; seed = 32'd0; out_ready = 1'b0;
`ifdef RANPERM_ABORT_EN
        abort = 1'b0;
`endif
        model_lfsr = SEED;

        tbl.push_back(mk(0, 32'd0,        -1, 0, 0, 0, -1, N));
        tbl.push_back(mk(1, 32'h12345678, -1, 0, 0, 0, -1, N));
        tbl.push_back(mk(1, 32'h12345678,  3, 5, 0, 0, -1, N));
        tbl.push_back(mk(1, 32'd0,        -1, 0, 0, 0, -1, N));
        tbl.push_back(mk(0, 32'd0,        -1, 0, 0, 1, -1, N));
        tbl.push_back(mk(0, 32'd0,         0, 3, 0, 0, -1, N));
        tbl.push_back(mk(0, 32'd0,     N - 1, 2, 0, 0, -1, N));
`ifdef RANPERM_ABORT_EN
        tbl.push_back(mk(0, 32'd0,        -1, 0, 0, 0,  4, 4));
        tbl.push_back(mk(0, 32'd0,        -1, 0, 0, 0, -1, N));
`endif
        for (int r = 0; r < 6; r++)
            tbl.push_back(mk(1'($urandom_range(0, 1)), $urandom, -1, 0, 1, 0, -1, N));

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < tbl.size(); t++) begin
            do_run(tbl[t]);
            if (t == 0) foreach (exp_perm[k]) first_perm[k] = exp_perm[k];
        end

        // Reset in the middle of SHUFFLE, then the next run must repeat the first permutation.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_index", 32'(out_index), 32'd0);
        chk("midrst_last", 32'(out_last), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        model_lfsr = SEED;
        do_run(mk(0, 32'd0, -1, 0, 0, 0, -1, N));
        foreach (got_perm[k]) chk("post_reset_perm", 32'(got_perm[k]), 32'(first_perm[k]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ranperm_seq_ctrl.md
Name: ranperm_seq_ctrl

Overview:
- Multi-cycle controller that sequences a Fisher-Yates shuffle over an internal N-entry index array.
- Performs one swap per cycle, driven by a 32-bit LFSR.
- Streams the finished permutation out over a valid/ready port.
- Sits between the host (start/seed control) and downstream consumers of random index order. It replaces a single-cycle, combinational-loop shuffle with a bounded-latency, synthesizable one.

Parameters:
- N, 16, permutation length; legal range 2..1024.
- W, $clog2(N), index width (derived; do not override).
- LFSR_SEED, 32'h0000ABCD, LFSR reset value and substitute for a zero seed.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new permutation; sampled only in IDLE.
- seed_valid  input  1  load seed into LFSR; sampled only in IDLE.
- seed  input  32  new LFSR value.
- busy  output  1  high in INIT, SHUFFLE, STREAM.
- done  output  1  one-cycle pulse after the last output beat.
- out_valid  output  1  permutation entry available.
- out_ready  input  1  consumer accepts entry.
- out_index  output  W  current permutation entry.
- out_last  output  1  high with entry N-1.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; lfsr=LFSR_SEED; counters=0; array contents don't-care.
  - busy=0, done=0, out_valid=0, out_index=0, out_last=0.
  - Reset asserted mid-operation aborts immediately. No done pulse is produced.
- LFSR step: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}. It advances only in SHUFFLE, once per cycle. Its value persists across runs and is not reloaded on start.
- Seed load: in IDLE, seed_valid=1 loads seed next edge. seed==0 loads LFSR_SEED instead (prevents lockup). seed_valid is ignored outside IDLE.
- IDLE: on start=1, go to INIT with k=0.
  - If seed_valid and start are asserted in the same cycle, the seed is loaded and the run uses the new seed.
  - start outside IDLE is ignored.
- INIT: array[k]<=k, k++ each cycle. Lasts N cycles, then SHUFFLE with i=N-1.
- SHUFFLE: one step per cycle.
  - j = (lfsr * (i+1)) >> 32, computed on the current lfsr. This is a 32xW+1 multiply taking the upper bits; no divider. j is always <= i.
  - Swap array[i] and array[j]; i==j is a legal no-op. i--; lfsr steps.
  - After the step with i==1, go to STREAM with k=0. Lasts N-1 cycles.
- STREAM:
  - out_valid=1, out_index=array[k], out_last=(k==N-1).
  - Handshake fires on out_valid&&out_ready, then k++.
  - While out_ready=0, out_index and out_last hold stable.
  - After the handshake with out_last=1, go to IDLE with out_valid=0 and pulse done=1 for exactly one cycle.
  - busy drops in the same cycle that done rises.
- Latency: start accepted at edge T gives first out_valid at T+2N (N INIT + N-1 SHUFFLE + 1 setup cycle). With out_ready held high, done pulses at T+3N.
- Output invariant: every run emits each value 0..N-1 exactly once.

Optional Feature:
- Macro RANPERM_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in INIT, SHUFFLE or STREAM forces IDLE at the next edge. out_valid, busy and out_last clear; done is not pulsed; lfsr keeps its current value.
  - abort in IDLE has no effect. If abort and start are asserted together in IDLE, start wins.
- Undefined: no abort port. A run can be terminated only by reset_n.

Test Plan:
- Reset values: drive reset_n low with clk idle, then release -> busy=0, done=0, out_valid=0, out_index=0, out_last=0. The first run matches the golden model seeded with 32'h0000ABCD.
- Full run: N=8, start at edge T, out_ready=1 -> out_valid first at T+16; 8 beats covering {0..7} exactly once; out_last on beat 8; done pulse at T+24; busy low from then on.
- Backpressure: during STREAM, hold out_ready=0 for 5 cycles at beat 3 -> out_index and out_last stable for all 5 cycles; no beat lost or duplicated; done delayed by 5 cycles.
- Seed handling:
  - seed=32'h12345678 with start in the same cycle, run twice with the same reload -> identical permutations matching the model.
  - seed=0 -> identical to a post-reset run.
  - start while busy -> ignored; beat count stays 8.
- Reset mid-SHUFFLE: assert reset_n low at cycle T+10 -> all outputs 0 immediately and no done pulse. The next run equals the first post-reset permutation.
- RANPERM_ABORT_EN: abort at beat 4 of STREAM -> out_valid=0 next cycle, no done pulse. The next run's permutation equals the model continued from the LFSR state at abort.
